// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register with a one-entry skid buffer.
// Holds the fetched PC/instruction pair for decode. It absorbs the single
// in-flight fetch that arrives after decode stalls, so no fetch is lost.
// Flush kills every held instruction and shows a NOP to decode at once.
//
// Parameters:
//   PC_W     PC width
//   INSTR_W  instruction width
//   NOP      instruction word shown when nothing valid is held
//   CNT_W    stall-counter width (only with IFID_STALL_CNT_EN)
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   stall       decode is holding; the main entry must not advance
//   flush       kill all held instructions, drop this cycle's fetch
//   if_valid    fetch presents if_pc/if_instr
//   if_pc       fetched PC
//   if_instr    fetched instruction
//   if_ready    fetch is accepted this cycle (combinational)
//   id_valid    id_pc/id_instr hold a live instruction (combinational mask)
//   id_pc       PC to decode (keeps the last PC when invalid)
//   id_instr    instruction to decode, NOP when not valid
//   stall_cnt   saturating count of stalled valid cycles
// Optional feature macro: IFID_STALL_CNT_EN adds the stall_cnt port and counter.
module if_id_pipe_reg #(
  parameter int unsigned          PC_W    = 16,
  parameter int unsigned          INSTR_W = 16,
  parameter logic [INSTR_W-1:0]   NOP     = INSTR_W'(16'h4000)
`ifdef IFID_STALL_CNT_EN
  ,
  parameter int unsigned          CNT_W   = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               if_valid,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               if_ready,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t state, stateNext;
  entry_t mainQ, mainNext;
  entry_t skidQ, skidNext;
  entry_t fetch;
  logic   accept;
  logic   mainValid;

  assign fetch     = '{pc: if_pc, instr: if_instr};
  assign mainValid = (state != EMPTY);
  assign accept    = if_valid && if_ready;

  // Handshake and decode-side view; flush masks the main entry immediately.
  assign if_ready = (state != TWO) && !flush;
  assign id_valid = mainValid && !flush;
  assign id_instr = id_valid ? mainQ.instr : NOP;
  assign id_pc    = mainQ.pc;

  // State and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      mainQ <= '{pc: '0, instr: NOP};
      skidQ <= '0;
    end else begin
      state <= stateNext;
      mainQ <= mainNext;
      skidQ <= skidNext;
    end
  end

  // Next-state and storage update.
  always_comb begin
    stateNext = state;
    mainNext  = mainQ;
    skidNext  = skidQ;
    if (flush) begin
      // Payloads may stay stale; EMPTY alone marks them dead.
      stateNext = EMPTY;
    end else if (!stall) begin
      unique case (state)
        TWO: begin
          stateNext = ONE;
          mainNext  = skidQ;
        end
        default: begin
          if (accept) begin
            stateNext = ONE;
            mainNext  = fetch;
          end else begin
            stateNext = EMPTY;
          end
        end
      endcase
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            stateNext = ONE;
            mainNext  = fetch;
          end
        end
        ONE: begin
          // Decode is holding main; park the in-flight fetch in the skid.
          if (accept) begin
            stateNext = TWO;
            skidNext  = fetch;
          end
        end
        default: stateNext = TWO;
      endcase
    end
  end

`ifdef IFID_STALL_CNT_EN
  // Saturating count of edges where decode stalls on a live instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && id_valid && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        if_ready;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_instr;

  logic [31:0] if_pc32;
  logic [31:0] if_instr32;
  logic        if_ready32;
  logic        id_valid32;
  logic [31:0] id_pc32;
  logic [31:0] id_instr32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_pipe_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
`ifdef IFID_STALL_CNT_EN
    , .stall_cnt()
`endif
  );

  if_id_pipe_reg #(.PC_W(32), .INSTR_W(32), .NOP(32'h0000_0013)) dut32 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc32), .if_instr(if_instr32),
    .if_ready(if_ready32), .id_valid(id_valid32), .id_pc(id_pc32), .id_instr(id_instr32)
`ifdef IFID_STALL_CNT_EN
    , .stall_cnt()
`endif
  );

`ifdef IFID_STALL_CNT_EN
  logic [3:0] stall_cnt4;
  logic       if_ready4;
  logic       id_valid4;
  logic [15:0] id_pc4;
  logic [15:0] id_instr4;
  if_id_pipe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready4), .id_valid(id_valid4), .id_pc(id_pc4), .id_instr(id_instr4),
    .stall_cnt(stall_cnt4)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic v, input logic [15:0] pc, input logic [15:0] instr);
    if_valid   = v;
    if_pc      = pc;
    if_instr   = instr;
    if_pc32    = {16'h0, pc};
    if_instr32 = {instr, instr};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    fetch(1'b0, 16'h0, 16'h0);
    #12;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_instr", 32'(id_instr), 32'h4000);
    chk("rst_pc", 32'(id_pc), 32'h0);
    chk("rst_ready", 32'(if_ready), 32'h1);
    chk("rst_instr32", id_instr32, 32'h0000_0013);

    // Streaming, no stall.
    fetch(1'b1, 16'd0, 16'h1111); step();
    chk("s0_valid", 32'(id_valid), 32'h1);
    chk("s0_pc", 32'(id_pc), 32'h0);
    chk("s0_instr", 32'(id_instr), 32'h1111);
    fetch(1'b1, 16'd1, 16'h2222); step();
    chk("s1_pc", 32'(id_pc), 32'h1);
    chk("s1_instr", 32'(id_instr), 32'h2222);
    chk("s1_instr32", id_instr32, 32'h2222_2222);
    fetch(1'b1, 16'd2, 16'h3333); step();
    chk("s2_valid", 32'(id_valid), 32'h1);
    chk("s2_instr", 32'(id_instr), 32'h3333);
    chk("s2_pc32", id_pc32, 32'h2);
    chk("s2_valid32", 32'(id_valid32), 32'h1);

    // Skid: main holds PC 4, in-flight PC 5 parks while stalled.
    fetch(1'b1, 16'd4, 16'h4444); step();
    stall = 1'b1;
    fetch(1'b1, 16'd5, 16'hAAAA);
    #1;
    chk("one_ready", 32'(if_ready), 32'h1);
    step();
    fetch(1'b0, 16'd0, 16'h0);
    chk("two_ready", 32'(if_ready), 32'h0);
    chk("two_pc", 32'(id_pc), 32'h4);
    chk("two_instr", 32'(id_instr), 32'h4444);
    stall = 1'b0;
    step();
    chk("rel_pc", 32'(id_pc), 32'h5);
    chk("rel_instr", 32'(id_instr), 32'hAAAA);
    chk("rel_ready", 32'(if_ready), 32'h1);
    step();
    chk("drain_valid", 32'(id_valid), 32'h0);
    chk("drain_instr", 32'(id_instr), 32'h4000);
    chk("drain_pc", 32'(id_pc), 32'h5);

    // Flush in TWO with stall held high.
    fetch(1'b1, 16'd6, 16'h6666); step();
    stall = 1'b1;
    fetch(1'b1, 16'd7, 16'h7777); step();
    chk("f_two_ready", 32'(if_ready), 32'h0);
    flush = 1'b1;
    fetch(1'b1, 16'd8, 16'h8888);
    #1;
    chk("f_valid", 32'(id_valid), 32'h0);
    chk("f_instr", 32'(id_instr), 32'h4000);
    chk("f_ready", 32'(if_ready), 32'h0);
    step();
    flush = 1'b0;
    fetch(1'b0, 16'd0, 16'h0);
    #1;
    chk("f_next_valid", 32'(id_valid), 32'h0);
    chk("f_next_ready", 32'(if_ready), 32'h1);
    stall = 1'b0;
    step();
    chk("f_drop_valid", 32'(id_valid), 32'h0);
    chk("f_drop_instr", 32'(id_instr), 32'h4000);

    // Flush in ONE drops the fetch offered in the same cycle.
    fetch(1'b1, 16'd9, 16'h9999); step();
    flush = 1'b1;
    fetch(1'b1, 16'd10, 16'hBBBB); step();
    flush = 1'b0;
    fetch(1'b0, 16'd0, 16'h0);
    #1;
    chk("f1_valid", 32'(id_valid), 32'h0);
    chk("f1_pc", 32'(id_pc), 32'h9);

    // Asynchronous reset mid-cycle with a live, stalled entry.
    fetch(1'b1, 16'd12, 16'hCCCC); step();
    stall = 1'b1;
    fetch(1'b0, 16'd0, 16'h0);
    chk("pre_rst_valid", 32'(id_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(id_valid), 32'h0);
    chk("arst_instr", 32'(id_instr), 32'h4000);
    chk("arst_pc", 32'(id_pc), 32'h0);
    chk("arst_ready", 32'(if_ready), 32'h1);
    chk("arst_instr32", id_instr32, 32'h0000_0013);
    step();
    rst = 1'b0;
    stall = 1'b0;

`ifdef IFID_STALL_CNT_EN
    // Stall counter: no count while EMPTY, then saturates at 15.
    rst = 1'b1; #1; rst = 1'b0;
    stall = 1'b1;
    step(); step(); step();
    chk("cnt_empty", 32'(stall_cnt4), 32'h0);
    fetch(1'b1, 16'd20, 16'hDDDD); step();
    fetch(1'b0, 16'd0, 16'h0);
    chk("cnt_load", 32'(stall_cnt4), 32'h0);
    step(); step(); step();
    chk("cnt_three", 32'(stall_cnt4), 32'h3);
    for (int i = 0; i < 20; i++) step();
    chk("cnt_sat", 32'(stall_cnt4), 32'hF);
    stall = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Parametrised IF/ID pipeline register with a one-entry skid buffer, sitting between the fetch stage (PC and synchronous instruction memory) and the decode stage. It holds the fetched PC/instruction pair for decode and absorbs the one in-flight fetch that arrives after decode asserts stall, so fetch never loses an instruction. Flush replaces the decode-side instruction with a NOP immediately. It replaces the fixed 16-bit IF/ID register with width-generic storage, explicit valid tracking and ready back-pressure.

## Interface
- PC_W, 16, PC width
- INSTR_W, 16, instruction width
- NOP, 16'h4000 (INSTR_W bits), instruction word presented when no valid instruction is held
- CNT_W, 16, stall-counter width (used only with IFID_STALL_CNT_EN)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode is holding; the main entry must not advance
- flush  in  1  kill all held instructions (taken branch/jump)
- if_valid  in  1  fetch presents a valid PC/instruction this cycle
- if_pc  in  PC_W  fetched PC
- if_instr  in  INSTR_W  fetched instruction
- if_ready  out  1  block accepts a fetch this cycle
- id_valid  out  1  id_instr/id_pc hold a live instruction
- id_pc  out  PC_W  PC to decode
- id_instr  out  INSTR_W  instruction to decode (NOP when not valid)
- stall_cnt  out  CNT_W  present only with IFID_STALL_CNT_EN

## Operation
- Storage: main entry {pc, instr, valid} drives decode; skid entry {pc, instr} holds the captured in-flight fetch.
- States: EMPTY (main invalid), ONE (main valid, skid empty), TWO (main and skid valid).
- Accept = if_valid && if_ready; if_ready = (state != TWO) && !flush, combinational.
- flush (any state, overrides stall): next state EMPTY; any fetch presented that cycle is dropped.
- No stall, no flush:
  - EMPTY/ONE + accept -> ONE, main <= fetch.
  - EMPTY/ONE, no accept -> EMPTY.
  - TWO -> ONE, main <= skid.
- Stall, no flush:
  - EMPTY + accept -> ONE, main <= fetch.
  - ONE + accept -> TWO, skid <= fetch; main unchanged.
  - ONE, no accept -> ONE. TWO -> TWO.
- Outputs: id_valid = main.valid && !flush; id_instr = id_valid ? main.instr : NOP; id_pc = main.pc (retains last PC when invalid).
- Reset: state EMPTY, main.pc = 0, main.instr = NOP, skid cleared, id_valid = 0, id_instr = NOP, id_pc = 0, if_ready = 1, stall_cnt = 0.

## Timing
- Latency: fetch accepted at edge N appears on id_* after edge N (same cycle decode samples it at N+1); 1-cycle throughput when no stall.
- Flush masks id_valid/id_instr combinationally in the cycle flush is high; state clears at the next edge.
- Stall release from TWO: skid appears on id_* one cycle after stall falls; if_ready rises in that same cycle (combinational from state ONE).
- Maximum occupancy 2; no fetch is ever dropped except by flush.
- Reset asserted mid-operation clears both entries asynchronously; outputs take reset values without waiting for clk.

## Configuration
- IFID_STALL_CNT_EN defined: stall_cnt port exists; counter increments on each edge where stall && id_valid && !flush; saturates at all-ones; cleared only by rst.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> id_valid=0, id_instr=16'h4000, id_pc=0, if_ready=1 without clock edge.
- Streaming: if_valid=1 with PC 0,1,2 / instr 0x1111,0x2222,0x3333, no stall -> id_* shows each pair one cycle later, id_valid continuous.
- Skid: main holds PC 4; raise stall, present PC 5/0xAAAA -> if_ready=0 next cycle, id_pc stays 4; drop stall -> next cycle id_pc=5, id_instr=0xAAAA, if_ready=1.
- Flush in TWO with stall high: flush=1 -> id_instr=0x4000 and id_valid=0 same cycle; next cycle state EMPTY, if_ready=1, presented fetch dropped.
- Parametrisation: PC_W=32, INSTR_W=32, NOP=32'h00000013 -> reset id_instr=0x00000013, streaming as above.
- IFID_STALL_CNT_EN, CNT_W=4: hold stall with valid main for 20 cycles -> stall_cnt saturates at 15; stall with EMPTY -> no increment.
